spi_slave_core: RTL and testbench
=================================

Name: spi_slave_core

Overview:
- SPI responder (slave) for the 32-bit SPI link driven by the team's SPI master core.
- Oversamples sclk, ss_n and mosi in the local system clock domain.
- Deserialises each MOSI frame into a parallel word, and serialises a preloaded word onto MISO.
- Used as the far-end device model in the bench and as an FPGA-side SPI peripheral behind an Avalon slave wrapper.
- Protocol: SPI mode 0 (CPOL=0, CPHA=0), MSB first, frames of DATA_WIDTH bits.

Parameters:
- DATA_WIDTH, 32, frame length in bits and width of the tx/rx words.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on sclk, ss_n and mosi (minimum 2).
- IDLE_WORD, 32'h0000_0000, word shifted out when no tx word is pending at frame start.

Ports:
- clk  input  1  system clock; f_clk >= 8 x f_sclk.
- reset  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from master; asynchronous to clk.
- ss_n  input  1  slave select, active low; asynchronous.
- mosi  input  1  serial data from master; asynchronous.
- miso  output  1  serial data to master.
- miso_oe  output  1  high while selected; external tristate enable.
- tx_data  input  DATA_WIDTH  word to send in the next frame.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  tx holding register empty.
- rx_data  output  DATA_WIDTH  last completed received frame.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- frame_abort  output  1  one-cycle pulse when ss_n rises mid-frame.
- tx_underrun  output  1  one-cycle pulse when a frame starts with no tx word pending.
- busy  output  1  high in ACTIVE state.

Behaviour:
- Reset (asynchronous, any time including mid-frame) forces these values:
  - miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, frame_abort=0, tx_underrun=0, busy=0.
  - Holding register empty, bit counter 0, state IDLE.
- Synchronisers: sclk, ss_n and mosi each pass through SYNC_STAGES FFs, then one history FF.
  - Edge events (sclk_rise, sclk_fall, ss_fall, ss_rise) are single-cycle pulses SYNC_STAGES+1 clk after the pin edge.
  - mosi is sampled from the synchronised copy aligned with sclk.
- TX holding register (1 entry):
  - A transfer occurs when tx_valid && tx_ready: the word is captured and tx_ready goes 0 on the next clk.
  - tx_ready returns to 1 the cycle after the word is moved into the shift register.
  - tx_valid while tx_ready=0 is ignored; the held word is not overwritten.
- State IDLE (miso_oe=0, busy=0):
  - On ss_fall, load tx_shift from the holding register if full, else from IDLE_WORD with a tx_underrun pulse.
  - Same cycle: drive miso=tx_shift MSB, miso_oe=1, bit_cnt=0, go to ACTIVE.
  - sclk edges in IDLE are ignored.
- State ACTIVE:
  - sclk_rise: rx_shift <= {rx_shift[W-2:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches DATA_WIDTH on a rise:
    - rx_data <= completed word, rx_valid pulse next cycle.
    - bit_cnt <= 0, reload_pending <= 1.
  - sclk_fall with reload_pending=0: shift tx_shift left, miso <= new MSB.
  - sclk_fall with reload_pending=1: reload tx_shift (holding register or IDLE_WORD + tx_underrun) and drive its MSB. This supports back-to-back frames under continuous ss_n low.
  - ss_rise with bit_cnt==0: clean end. Go to IDLE, miso_oe=0, miso=0.
  - ss_rise with bit_cnt!=0: frame_abort pulse, partial rx discarded (rx_data unchanged, no rx_valid), go to IDLE.
  - A word already moved to tx_shift is lost on abort; the holding register is untouched.
- Simultaneous events:
  - ss_rise takes priority over same-cycle sclk edges.
  - A tx_valid capture in the same cycle as a reload is not used for that reload. It lands in the holding register for the next frame.
- rx_valid fires regardless of downstream readiness. rx_data is overwritten by the next frame (no overrun flag).
- busy = (state==ACTIVE).

Test Plan:
1. Preload tx_data=32'hA5A5_0F0F; master sends 32'h1234_5678, clk 10 ns, sclk 160 ns.
   -> rx_valid pulses once with rx_data=32'h1234_5678; master captures 32'hA5A5_0F0F; tx_ready returns to 1 after ss_fall.
2. No preload; master sends 32'hFFFF_FFFF.
   -> tx_underrun pulse at frame start; MISO shifts IDLE_WORD=0; rx_data=32'hFFFF_FFFF.
3. ss_n held low for 64 sclk; words 32'hDEAD_BEEF then 32'hCAFE_F00D; tx words 32'h1111_1111 and 32'h2222_2222 (second loaded mid-frame 1).
   -> two rx_valid pulses with the correct words; MISO carries 32'h1111_1111 then 32'h2222_2222.
4. ss_n rises after 13 sclk rises.
   -> frame_abort pulse; no rx_valid; rx_data keeps its previous value; next full frame 32'h0000_00FF is received correctly.
5. tx_valid asserted twice while tx_ready=0 (32'hAAAA_AAAA accepted, then 32'hBBBB_BBBB).
   -> next frame sends 32'hAAAA_AAAA only.
6. reset asserted at bit 20 of an active frame.
   -> all outputs at reset values within the same cycle; no rx_valid; the next frame after reset is received correctly.

Source files
------------

// File: rtl/spi_slave_core.sv
// Purpose: SPI mode-0 responder (MSB first, DATA_WIDTH-bit frames), pins oversampled in the clk domain.
// Latency: pin edges act SYNC_STAGES+1 clk after they occur; rx_valid rises one clk after the last sclk rise is seen.
// Backpressure: none on rx (rx_valid always fires, rx_data overwritten); tx side is a 1-entry holding register gated by tx_ready.
module spi_slave_core #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_abort,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_hist, ss_hist;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;

  logic                   hold_full;
  logic [DATA_WIDTH-1:0]  hold_data;
  logic [DATA_WIDTH-1:0]  load_word;

  // Only the bits below the MSB are kept: the MSB lives in the miso flop.
  logic [DATA_WIDTH-2:0]  tx_shift;
  logic [DATA_WIDTH-2:0]  rx_shift;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   reload_pending;

  logic start_frame, load_tx, shift_tx, sample_rx, go_idle, abort;
  logic frame_done;

  // Metastability chains plus one history stage for edge detection; ss_n idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_hist <= 1'b0;
      ss_hist   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_hist <= sclk_s;
      ss_hist   <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign sclk_fall = ~sclk_s & sclk_hist;
  assign ss_fall   = ~ss_s & ss_hist;
  assign ss_rise   = ss_s & ~ss_hist;

  // Word presented to the shifter at a frame start or back-to-back reload.
  assign load_word  = hold_full ? hold_data : IDLE_WORD;
  assign frame_done = sample_rx && (bit_cnt == CNT_W'(DATA_WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and per-cycle datapath strobes; ss_rise wins over sclk edges.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    load_tx     = 1'b0;
    shift_tx    = 1'b0;
    sample_rx   = 1'b0;
    go_idle     = 1'b0;
    abort       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_fall) begin
          start_frame = 1'b1;
          load_tx     = 1'b1;
          state_nxt   = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise) begin
          go_idle   = 1'b1;
          abort     = (bit_cnt != '0);
          state_nxt = ST_IDLE;
        end else begin
          sample_rx = sclk_rise;
          if (sclk_fall) begin
            load_tx  = reload_pending;
            shift_tx = ~reload_pending;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Holding register: a load drains it; a capture fills it only when empty,
  // so a word arriving in the same cycle as a reload waits for the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (load_tx && hold_full) begin
      hold_full <= 1'b0;
    end else if (tx_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end
  end

  // Shift registers, bit counter, rx word and one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_shift       <= '0;
      rx_shift       <= '0;
      bit_cnt        <= '0;
      reload_pending <= 1'b0;
      miso           <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      frame_abort    <= 1'b0;
      tx_underrun    <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_abort <= 1'b0;
      tx_underrun <= 1'b0;

      if (load_tx) begin
        tx_shift       <= load_word[DATA_WIDTH-2:0];
        miso           <= load_word[DATA_WIDTH-1];
        tx_underrun    <= ~hold_full;
        reload_pending <= 1'b0;
      end else if (shift_tx) begin
        tx_shift <= {tx_shift[DATA_WIDTH-3:0], 1'b0};
        miso     <= tx_shift[DATA_WIDTH-2];
      end

      if (start_frame) begin
        bit_cnt <= '0;
      end

      if (sample_rx) begin
        rx_shift <= {rx_shift[DATA_WIDTH-3:0], mosi_s};
        if (frame_done) begin
          rx_data        <= {rx_shift, mosi_s};
          rx_valid       <= 1'b1;
          bit_cnt        <= '0;
          reload_pending <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end

      // Any partial rx bits are simply left behind; the next frame shifts them out.
      if (go_idle) begin
        miso           <= 1'b0;
        bit_cnt        <= '0;
        reload_pending <= 1'b0;
        frame_abort    <= abort;
      end
    end
  end

  assign busy     = (state == ST_ACTIVE);
  assign miso_oe  = (state == ST_ACTIVE);
  assign tx_ready = ~hold_full;

endmodule

// File: tb/tb_spi_slave_core.sv
// Purpose: randomized + directed bench for spi_slave_core with a frame-level reference model and rx scoreboard.
// Latency: the master bit-bangs sclk at 60-100 ns half periods against a 10 ns clk.
// Backpressure: tx words are offered with tx_valid and held until tx_ready is seen.
`timescale 1ns/1ps
module tb_spi_slave_core;
  localparam int W = 32;
  localparam logic [W-1:0] IDLE = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sclk = 1'b0;
  logic         ss_n = 1'b1;
  logic         mosi = 1'b0;
  logic         miso, miso_oe, tx_ready, rx_valid, frame_abort, tx_underrun, busy;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic [W-1:0] rx_data;

  spi_slave_core #(.DATA_WIDTH(W), .SYNC_STAGES(2), .IDLE_WORD(IDLE)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_abort(frame_abort), .tx_underrun(tx_underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  logic [W-1:0] rx_q[$];
  int           exp_underrun = 0, obs_underrun = 0;
  int           exp_abort = 0, obs_abort = 0;
  // Reference model: holding register contents and last good rx word.
  logic         m_hold_full = 1'b0;
  logic [W-1:0] m_hold = '0;
  logic [W-1:0] exp_last_rx = '0;
  int           half = 80;
  logic [W-1:0] mw[0:3];
  bit           mid_push = 1'b0;
  logic [W-1:0] mid_word = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every rx_valid and counts status pulses.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (rx_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected: got rx_valid with %h expected no frame", rx_data);
      end else begin
        logic [W-1:0] e;
        e = rx_q.pop_front();
        chk("rx_data", rx_data, e);
      end
    end
    if (tx_underrun) obs_underrun++;
    if (frame_abort) obs_abort++;
  end

  // A word moves into the shifter: from the holding register if full, else the idle word.
  task automatic model_load(output logic [W-1:0] w);
    if (m_hold_full) begin
      w = m_hold;
      m_hold_full = 1'b0;
    end else begin
      w = IDLE;
      exp_underrun++;
    end
  endtask

  task automatic tx_push(input logic [W-1:0] w);
    int n;
    n = 0;
    @(negedge clk);
    tx_data = w;
    tx_valid = 1'b1;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      total++;
      bad++;
      $display("FAIL tx_push_timeout: tx_ready got 0 expected 1");
      tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    m_hold = w;
    m_hold_full = 1'b1;
    chk("tx_ready_after_capture", {31'b0, tx_ready}, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_miso"}, {31'b0, miso}, 0);
    chk({tag, "_miso_oe"}, {31'b0, miso_oe}, 0);
    chk({tag, "_tx_ready"}, {31'b0, tx_ready}, 1);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_valid"}, {31'b0, rx_valid}, 0);
    chk({tag, "_frame_abort"}, {31'b0, frame_abort}, 0);
    chk({tag, "_tx_underrun"}, {31'b0, tx_underrun}, 0);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
  endtask

  // One ss_n-low session: nframes full frames, then optionally a partial frame of
  // part_bits bits (aborted), or a reset after rst_bit bits of the first frame.
  task automatic session(input int nframes, input int part_bits, input int rst_bit);
    logic [W-1:0] exp_tx, cap, wd;
    int nf, nb;
    nf = nframes + ((part_bits > 0) ? 1 : 0);
    model_load(exp_tx);
    ss_n = 1'b0;
    mosi = mw[0][W-1];
    #(half);
    for (int f = 0; f < nf; f++) begin
      nb = (f < nframes) ? W : part_bits;
      wd = mw[f];
      cap = '0;
      for (int b = 0; b < nb; b++) begin
        sclk = 1'b1;
        cap = {cap[W-2:0], miso};
        if (nb == W && b == W - 1) begin
          rx_q.push_back(wd);
          exp_last_rx = wd;
        end
        #(half);
        sclk = 1'b0;
        if (b < nb - 1) mosi = wd[W-2-b];
        else if (f + 1 < nf) mosi = mw[f+1][W-1];
        if (nb == W && b == W - 1) begin
          chk("miso_word", cap, exp_tx);
          model_load(exp_tx);
        end
        if (mid_push && f == 0 && b == 8) begin
          tx_push(mid_word);
          mid_push = 1'b0;
        end
        if (rst_bit > 0 && f == 0 && b == rst_bit - 1) begin
          #(half / 2);
          reset = 1'b1;
          #1;
          check_reset_outputs("mid_reset");
          ss_n = 1'b1;
          mosi = 1'b0;
          m_hold_full = 1'b0;
          exp_last_rx = '0;
          repeat (3) @(negedge clk);
          reset = 1'b0;
          return;
        end
        #(half);
      end
      if (nb < W) begin
        chk("miso_partial", cap, exp_tx >> (W - nb));
        exp_abort++;
      end
    end
    ss_n = 1'b1;
  endtask

  task automatic settle_and_check(input string tag);
    repeat (20) @(negedge clk);
    chk({tag, "_underruns"}, obs_underrun, exp_underrun);
    chk({tag, "_aborts"}, obs_abort, exp_abort);
    chk({tag, "_rx_pending"}, rx_q.size(), 0);
    chk({tag, "_rx_data_kept"}, rx_data, exp_last_rx);
    chk({tag, "_busy_idle"}, {31'b0, busy}, 0);
    chk({tag, "_tx_ready"}, {31'b0, tx_ready}, {31'b0, ~m_hold_full});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int nfr, pb;
    #23;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Preloaded word out, master word in.
    tx_push(32'hA5A5_0F0F);
    mw[0] = 32'h1234_5678;
    session(1, 0, 0);
    settle_and_check("t1");

    // Nothing pending: idle word and an underrun at frame start.
    mw[0] = 32'hFFFF_FFFF;
    session(1, 0, 0);
    settle_and_check("t2");

    // Back-to-back frames under continuous ss_n low, second tx word loaded mid-frame.
    tx_push(32'h1111_1111);
    mid_push = 1'b1;
    mid_word = 32'h2222_2222;
    mw[0] = 32'hDEAD_BEEF;
    mw[1] = 32'hCAFE_F00D;
    session(2, 0, 0);
    settle_and_check("t3");

    // Abort after 13 bits, then a clean frame.
    mw[0] = $urandom;
    session(0, 13, 0);
    settle_and_check("t4a");
    mw[0] = 32'h0000_00FF;
    session(1, 0, 0);
    settle_and_check("t4b");

    // Offers while the holding register is full are ignored.
    tx_push(32'hAAAA_AAAA);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tx_data = 32'hBBBB_BBBB;
      tx_valid = 1'b1;
      @(negedge clk);
      chk("tx_ready_while_full", {31'b0, tx_ready}, 0);
      tx_valid = 1'b0;
    end
    mw[0] = $urandom;
    session(1, 0, 0);
    settle_and_check("t5");

    // Reset at bit 20, then a normal frame.
    tx_push($urandom);
    mw[0] = $urandom;
    session(1, 0, 20);
    settle_and_check("t6a");
    tx_push($urandom);
    mw[0] = $urandom;
    session(1, 0, 0);
    settle_and_check("t6b");

    // Random sessions.
    for (int i = 0; i < 12; i++) begin
      half = $urandom_range(60, 100);
      if (!m_hold_full && $urandom_range(0, 1) == 1) tx_push($urandom);
      nfr = $urandom_range(1, 2);
      pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31) : 0;
      for (int k = 0; k < 4; k++) mw[k] = $urandom;
      session(nfr, pb, 0);
      settle_and_check("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
